fpadd_scheduler: RTL and testbench

Sequencing and arbitration controller that shares one combinational single-precision adder (`adderunit`, ports `dataA`, `dataB`, `dataR`) between up to N_REQ requesters. Each requester hands over one operand pair with a valid/ready handshake. The scheduler registers the operands, drives the adder and registers its result. It returns the sum with the requester's index on a single response channel that supports backpressure. Zero operands bypass the adder, because the adder does not handle them.

---
 rtl/fpadd_pkg.sv | 20 ++
 rtl/adderunit.sv | 90 +++++++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fpadd_scheduler.sv | 130 +++++++++++++
 tb/tb_fpadd_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpadd_pkg.sv
// Shared types and IEEE-754 single-precision helpers for the adder scheduler.
package fpadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int FP_W    = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MANT_W  = 23;

    // Sign bit is ignored so that both +0 and -0 count as zero.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return (x[EXP_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/adderunit.sv
// Combinational single-precision adder for nonzero normal operands, round-to-nearest-even.
module adderunit
    import fpadd_pkg::*;
(
    input  logic [FP_W-1:0] dataA,
    input  logic [FP_W-1:0] dataB,
    output logic [FP_W-1:0] dataR
);

    logic              w_swap;
    logic [FP_W-1:0]   w_big;
    logic [FP_W-1:0]   w_small;
    logic [7:0]        w_diff;
    logic [26:0]       w_small_full;
    logic [26:0]       w_small_sh;
    logic              w_sticky;
    logic [26:0]       w_small_al;
    logic [27:0]       w_big_full;
    logic [27:0]       w_sum;
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp;
    logic              w_round_up;
    logic [24:0]       w_mant_rnd;
    logic signed [9:0] w_exp_fin;
    logic [MANT_W-1:0] w_frac;

    // Order by magnitude so the subtraction below never goes negative.
    assign w_swap  = dataB[EXP_MSB:0] > dataA[EXP_MSB:0];
    assign w_big   = w_swap ? dataB : dataA;
    assign w_small = w_swap ? dataA : dataB;
    assign w_diff  = w_big[EXP_MSB:EXP_LSB] - w_small[EXP_MSB:EXP_LSB];

    assign w_small_full = {1'b1, w_small[MANT_W-1:0], 3'b000};
    assign w_big_full   = {2'b01, w_big[MANT_W-1:0], 3'b000};

    always_comb begin
        w_small_sh = '0;
        w_sticky   = 1'b0;
        if (w_diff >= 8'd27) begin
            w_sticky = |w_small_full;
        end else begin
            w_small_sh = w_small_full >> w_diff;
            w_sticky   = |(w_small_full & ~({27{1'b1}} << w_diff));
        end
    end

    assign w_small_al = {w_small_sh[26:1], w_small_sh[0] | w_sticky};
    assign w_sum = (w_big[31] == w_small[31]) ? (w_big_full + {1'b0, w_small_al})
                                              : (w_big_full - {1'b0, w_small_al});

    always_comb begin
        w_lz = 5'd0;
        for (int k = 0; k < 27; k++) begin
            if (w_sum[k]) w_lz = 5'(26 - k);
        end
    end

    // Bits [26:3] hold the 24-bit significand; [2] guard, [1:0] round/sticky.
    always_comb begin
        w_norm = '0;
        w_exp  = '0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = $signed({2'b00, w_big[EXP_MSB:EXP_LSB]}) + 10'sd1;
        end else begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = $signed({2'b00, w_big[EXP_MSB:EXP_LSB]}) - $signed({5'b00000, w_lz});
        end
    end

    assign w_round_up = w_norm[2] & ((|w_norm[1:0]) | w_norm[3]);
    assign w_mant_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    assign w_exp_fin  = w_exp + (w_mant_rnd[24] ? 10'sd1 : 10'sd0);
    assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

    always_comb begin
        dataR = '0;
        if (w_sum == '0) begin
            dataR = '0;
        end else if (w_exp_fin >= 10'sd255) begin
            dataR = {w_big[31], 8'hFF, {MANT_W{1'b0}}};
        end else if (w_exp_fin <= 10'sd0) begin
            dataR = {w_big[31], 31'd0};
        end else begin
            dataR = {w_big[31], w_exp_fin[7:0], w_frac};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (mod N_REQ) wins while enabled.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic [ID_W-1:0]  w_idx [N_REQ];
    logic [N_REQ-1:0] w_hit;
    logic [ID_W-1:0]  w_sel;
    logic             w_any;

    // ptr < N_REQ and offset < N_REQ, so one conditional subtract wraps the sum.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [ID_W:0] w_sum;
        assign w_sum       = {1'b0, ptr} + (ID_W+1)'(gi);
        assign w_idx[gi]   = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                         : w_sum[ID_W-1:0];
        assign w_hit[gi]   = req[w_idx[gi]];
    end

    always_comb begin
        w_sel = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) w_sel = w_idx[k];
        end
    end

    assign w_any     = |req;
    assign grant     = (enable && w_any) ? (N_REQ'(1) << w_sel) : '0;
    assign grant_idx = w_sel;

endmodule

// File: rtl/fpadd_scheduler.sv
// Shares one combinational FP adder among N_REQ requesters; one op in flight, result held until taken.
module fpadd_scheduler
    import fpadd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][FP_W-1:0]  req_a,
    input  logic [N_REQ-1:0][FP_W-1:0]  req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [FP_W-1:0]             rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy,
    output logic [15:0]                 done_count
);

    sched_state_t    r_state;
    sched_state_t    w_state_next;
    logic [ID_W-1:0] r_rr_ptr;
    logic [FP_W-1:0] r_op_a;
    logic [FP_W-1:0] r_op_b;
    logic [ID_W-1:0] r_op_id;
    logic [FP_W-1:0] r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_done_count;

    logic             w_rsp_fire;
    logic             w_grant_en;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_xfer;
    logic [FP_W-1:0]  w_adder_r;
    logic [FP_W-1:0]  w_result;
    logic             w_a_zero;
    logic             w_b_zero;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .enable    (w_grant_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    adderunit u_add (
        .dataA (r_op_a),
        .dataB (r_op_b),
        .dataR (w_adder_r)
    );

    // Accepting the next op in the same cycle the response leaves keeps one op every 2 cycles.
    assign w_rsp_fire = (r_state == RESP) && rsp_ready;
    assign w_grant_en = !rst && ((r_state == IDLE) || w_rsp_fire);
    assign req_ready  = w_grant;
    assign w_xfer     = |(req_valid & w_grant);

    always_comb begin
        w_state_next = r_state;
        rsp_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) w_state_next = EXEC;
            end
            EXEC: begin
                busy         = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = w_xfer ? EXEC : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The adder cannot take zero operands, so those cases are resolved here.
    assign w_a_zero = fp_is_zero(r_op_a);
    assign w_b_zero = fp_is_zero(r_op_b);

    always_comb begin
        w_result = w_adder_r;
        case ({w_a_zero, w_b_zero})
            2'b10:   w_result = r_op_b;
            2'b01:   w_result = r_op_a;
            2'b11:   w_result = {r_op_a[31] & r_op_b[31], 31'd0};
            default: w_result = w_adder_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_done_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_op_a   <= req_a[w_grant_idx];
                r_op_b   <= req_b[w_grant_idx];
                r_op_id  <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= r_op_id;
            end
            if (w_rsp_fire) r_done_count <= r_done_count + 16'd1;
        end
    end

    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Bench for fpadd_scheduler: vector table, directed corner sequences and randomized traffic.
module tb_fpadd_scheduler;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][31:0]    req_a;
    logic [N-1:0][31:0]    req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [1:0]            rsp_id;
    logic                  busy;
    logic [15:0]           done_count;

    fpadd_scheduler #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    localparam int N_TBL = 11;
    vec_t tbl [N_TBL];

    int          n_cmp;
    int          n_bad;
    // Reference model of the request/response timeline.
    int          cyc;
    bit          outst;
    int          t_acc;
    logic [31:0] exp_data;
    int          exp_id;
    int          ptr_m;
    int          done_m;
    logic [31:0] exp_for [N];
    int          last_grant;
    int          g_seq [$];
    int          g_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Exact for operands from rand_fp: value scaled by 2^30 fits a longint.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, s, mag;
        int p;
        logic [31:0] m;
        bit az, bz;
        az = (a[30:0] == 31'd0);
        bz = (b[30:0] == 31'd0);
        if (az && bz) return {a[31] & b[31], 31'd0};
        if (az) return b;
        if (bz) return a;
        va = longint'({1'b1, a[22:0]}) <<< (int'(a[30:23]) - 120);
        vb = longint'({1'b1, b[22:0]}) <<< (int'(b[30:23]) - 120);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        s = va + vb;
        if (s == 0) return 32'd0;
        mag = (s < 0) ? -s : s;
        p = 0;
        for (int k = 0; k < 63; k++) if (mag[k]) p = k;
        if (p >= 23) m = 32'(mag >> (p - 23));
        else         m = 32'(mag << (23 - p));
        return {(s < 0), 8'(p + 97), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) return {s, 31'd0};
        e = 8'(120 + $urandom_range(0, 15));
        f = 7'($urandom_range(0, 127));
        return {s, e, f, 16'd0};
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        req_valid[i] = 1'b1;
        req_a[i]     = a;
        req_b[i]     = b;
        exp_for[i]   = r;
    endtask

    task automatic set_rand_req(input int i);
        logic [31:0] a, b;
        a = rand_fp();
        b = rand_fp();
        set_req(i, a, b, ref_add(a, b));
    endtask

    // Called at posedge+1 after stimulus is set; returns at the next posedge+1.
    task automatic cycle();
        bit           exp_rv;
        bit           win;
        int           g;
        logic [N-1:0] exp_rdy;
        #1;
        exp_rv = outst && (cyc >= t_acc + 2);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("busy", 32'(busy), 32'(outst));
        check("done_count", 32'(done_count), 32'(done_m & 32'hFFFF));
        if (exp_rv) begin
            check("rsp_data", rsp_data, exp_data);
            check("rsp_id", 32'(rsp_id), 32'(exp_id));
        end
        win = !rst && (!outst || (exp_rv && rsp_ready));
        g = -1;
        if (win) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr_m + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_grant = g;
        if (rst) begin
            outst  = 1'b0;
            ptr_m  = 0;
            done_m = 0;
        end else begin
            if (exp_rv && rsp_ready) begin
                outst = 1'b0;
                done_m++;
            end
            if (g >= 0) begin
                outst    = 1'b1;
                t_acc    = cyc;
                exp_data = exp_for[g];
                exp_id   = g;
                ptr_m    = (g + 1) % N;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            cycle();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; outst = 1'b0; t_acc = 0;
        exp_data = '0; exp_id = 0; ptr_m = 0; done_m = 0; last_grant = -1;
        for (int i = 0; i < N; i++) exp_for[i] = '0;
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;

        tbl[0]  = '{32'h40600000, 32'h40400000, 32'h40D00000};
        tbl[1]  = '{32'h00000000, 32'h40400000, 32'h40400000};
        tbl[2]  = '{32'h80000000, 32'h80000000, 32'h80000000};
        tbl[3]  = '{32'h40400000, 32'h80000000, 32'h40400000};
        tbl[4]  = '{32'h00000000, 32'h80000000, 32'h00000000};
        tbl[5]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        tbl[6]  = '{32'h40A00000, 32'hC0400000, 32'h40000000};
        tbl[7]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        tbl[8]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};
        tbl[9]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
        tbl[10] = '{32'h4B800000, 32'h3F800000, 32'h4B800000};

        // Reset state, with every requester already asking.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 32'h40000000);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        cycle();
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        cycle();

        // Vector table through requester 1.
        for (int i = 0; i < N_TBL; i++) begin
            set_req(1, tbl[i].a, tbl[i].b, tbl[i].r);
            cycle();
            check("tbl_grant", 32'(last_grant), 32'd1);
            req_valid[1] = 1'b0;
            cycle();
            check("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
            check("tbl_rsp_data", rsp_data, tbl[i].r);
            check("tbl_rsp_id", 32'(rsp_id), 32'd1);
            cycle();
            if (i == 0) check("first_done_count", 32'(done_count), 32'd1);
        end

        // Round-robin from reset with everyone valid.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_rand_req(i);
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (last_grant >= 0) begin
                g_seq.push_back(last_grant);
                g_cyc.push_back(cyc);
            end
        end
        check("rr_grant_count", 32'(g_seq.size()), 32'd5);
        for (int k = 0; k < 5 && k < g_seq.size(); k++) begin
            check("rr_order", 32'(g_seq[k]), 32'(k % N));
            if (k > 0) check("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd2);
        end
        req_valid = '0;
        wait_idle();

        // Backpressure: response held, grant window closed, then same-cycle grant.
        rsp_ready = 1'b0;
        set_req(3, 32'h40600000, 32'h40400000, 32'h40D00000);
        cycle();
        check("bp_grant", 32'(last_grant), 32'd3);
        req_valid[3] = 1'b0;
        set_req(0, 32'h3F800000, 32'h00000000, 32'h3F800000);
        cycle();
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, 32'h40D00000);
            check("bp_rsp_id", 32'(rsp_id), 32'd3);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_same_cycle_grant", 32'(last_grant), 32'd0);
        req_valid[0] = 1'b0;

        // Reset while requester 0's op is in EXEC.
        check("rst_in_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
            cycle();
        end
        check("rst_done_count", 32'(done_count), 32'd0);
        set_req(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        set_req(0, 32'h40400000, 32'h40400000, 32'h40C00000);
        cycle();
        check("rst_ptr_grant", 32'(last_grant), 32'd0);
        req_valid[0] = 1'b0;
        cycle();
        cycle();
        check("rst_next_grant", 32'(last_grant), 32'd1);
        req_valid = '0;
        wait_idle();

        // Fairness: requester 2 jumps in while requester 0 keeps asking.
        set_rand_req(0);
        cycle();
        check("fair_first", 32'(last_grant), 32'd0);
        set_rand_req(2);
        cycle();
        cycle();
        check("fair_second", 32'(last_grant), 32'd2);
        req_valid[2] = 1'b0;
        cycle();
        cycle();
        check("fair_third", 32'(last_grant), 32'd0);
        req_valid = '0;
        wait_idle();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
            end
            cycle();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle();
        check("final_done_count", 32'(done_count), 32'(done_m & 32'hFFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
